// File: rtl/div_unit_pkg.sv
// Shared types and constants for the EX-stage radix-2 restoring divider.
// State codes and ready levels are used by div_unit and by the EX-stage mux.
package div_unit_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU beside the ALU.
// Returns {remainder, quotient} for HI/LO and stalls the pipe while busy.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   opdata1,
    input  logic [DATA_W-1:0]   opdata2,
    input  logic                annul,
    output logic [2*DATA_W-1:0] result,
    output logic                ready,
    output logic                stall_req
);

    div_state_e          r_state;
    div_state_e          w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_divisor;
    logic                r_qsign;
    logic                r_rsign;
    logic [2*DATA_W-1:0] r_result;
    logic                r_ready;

    logic                w_accept;
    logic                w_op1_neg;
    logic                w_op2_neg;
    logic [DATA_W-1:0]   w_abs1;
    logic [DATA_W-1:0]   w_abs2;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_trial;
    logic                w_fit;
    logic [DATA_W-1:0]   w_rem_nx;
    logic [DATA_W-1:0]   w_quo_nx;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;
    logic                w_last;
    logic                w_abort;

    assign w_accept  = start & ~annul;
    assign w_abort   = annul & (r_state != DIV_FREE);
    assign w_op1_neg = signed_div & opdata1[DATA_W-1];
    assign w_op2_neg = signed_div & opdata2[DATA_W-1];
    assign w_abs1    = w_op1_neg ? -opdata1 : opdata1;
    assign w_abs2    = w_op2_neg ? -opdata2 : opdata2;

    // Restoring step: the extra top bit of the trial is the borrow.
    assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_divisor};
    assign w_fit     = ~w_trial[DATA_W];
    assign w_rem_nx  = w_fit ? w_trial[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
    assign w_quo_nx  = {r_quo[DATA_W-2:0], w_fit};
    assign w_quo_fix = r_qsign ? -r_quo : r_quo;
    assign w_rem_fix = r_rsign ? -r_rem : r_rem;
    assign w_last    = (r_cnt == CNT_W'(DATA_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DIV_FREE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = DIV_FREE;
        end else begin
            unique case (r_state)
                DIV_FREE: begin
                    if (w_accept) begin
                        w_next_state = (opdata2 == '0) ? DIV_BY_ZERO : DIV_ON;
                    end
                end
                DIV_BY_ZERO: w_next_state = DIV_END;
                DIV_ON: begin
                    if (w_last) begin
                        w_next_state = DIV_END;
                    end
                end
                DIV_END: begin
                    if (!start) begin
                        w_next_state = DIV_FREE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        result    = r_result;
        ready     = r_ready;
        stall_req = start & ~r_ready;
    end

    // An abort only drops ready; the last result stays on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_qsign   <= 1'b0;
            r_rsign   <= 1'b0;
            r_result  <= '0;
            r_ready   <= DIV_RESULT_NOT_READY;
        end else if (w_abort) begin
            r_ready <= DIV_RESULT_NOT_READY;
        end else begin
            unique case (r_state)
                DIV_FREE: begin
                    r_ready <= DIV_RESULT_NOT_READY;
                    if (w_accept && (opdata2 != '0)) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_abs1;
                        r_divisor <= w_abs2;
                        r_qsign   <= w_op1_neg ^ w_op2_neg;
                        r_rsign   <= w_op1_neg;
                    end
                end
                DIV_BY_ZERO: begin
                    r_result <= '0;
                end
                DIV_ON: begin
                    if (w_last) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= DIV_RESULT_READY;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DIV_END: begin
                    if (!start) begin
                        r_result <= '0;
                        r_ready  <= DIV_RESULT_NOT_READY;
                    end else begin
                        r_ready <= DIV_RESULT_READY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed DIV/DIVU vectors, latency,
// annul and asynchronous reset behaviour.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;
    logic        stall_req;

    int total = 0;
    int bad = 0;
    logic [63:0] sb[$];
    logic prev_ready = 1'b0;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every rising ready consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && ready && !prev_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", result, 64'hx);
            end else begin
                check("result", result, sb.pop_front());
            end
        end
        prev_ready <= ready;
    end

    task automatic issue(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int lat, input int drop_at,
                         input bit hold_end);
        int n;
        bit seen;
        sb.push_back(exp);
        start = 1'b1;
        signed_div = sgn;
        opdata1 = a;
        opdata2 = b;
        @(posedge clk); #1;
        check("stall_busy", 64'(stall_req), 64'd1);
        opdata1 = ~a;
        opdata2 = b + 32'd1;
        n = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (drop_at != 0 && k == drop_at) start = 1'b0;
            @(posedge clk); #1;
            n = k;
            if (ready) seen = 1'b1;
        end
        check("latency", 64'(seen ? n : 0), 64'(lat));
        check("stall_done", 64'(stall_req), 64'd0);
        if (!hold_end) begin
            start = 1'b0;
            @(posedge clk); #1;
            check("release", {63'd0, ready} | result, 64'd0);
        end
    endtask

    initial begin
        int cnt_rdy;
        #2;
        check("reset", {result[62:0], ready} | 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0, 1'b0);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2,
              {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0, 1'b0);
        issue(1'b1, 32'd7, 32'd0, 64'd0, 2, 0, 1'b0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
              {32'd0, 32'h8000_0000}, 33, 0, 1'b0);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE,
              {32'd1, 32'hFFFF_FFFD}, 33, 0, 1'b0);
        issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
              {32'hFFFF_FFFE, 32'd14}, 33, 0, 1'b0);
        issue(1'b0, 32'hFFFF_FFFF, 32'h10,
              {32'hF, 32'h0FFF_FFFF}, 33, 0, 1'b0);
        issue(1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33, 10, 1'b0);

        // Abort after ten iterations.
        start = 1'b1;
        signed_div = 1'b0;
        opdata1 = 32'd1000;
        opdata2 = 32'd3;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check("annul_ready", 64'(ready), 64'd0);
        annul = 1'b0;
        cnt_rdy = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) cnt_rdy++;
        end
        check("annul_quiet", 64'(cnt_rdy), 64'd0);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1,
              {32'd0, 32'hFFFF_FFFF}, 33, 0, 1'b0);

        // Asynchronous reset while a result is held.
        issue(1'b0, 32'd50, 32'd8, {32'd2, 32'd6}, 33, 0, 1'b1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_end", {63'd0, ready} | result, 64'd0);
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an iteration run.
        start = 1'b1;
        opdata1 = 32'd77;
        opdata2 = 32'd5;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_on", {63'd0, ready} | result, 64'd0);
        start = 1'b0;
        rst = 1'b0;
        cnt_rdy = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) cnt_rdy++;
        end
        check("rst_quiet", 64'(cnt_rdy), 64'd0);
        issue(1'b1, 32'hFFFF_FFCE, 32'd7,
              {32'hFFFF_FFFF, 32'hFFFF_FFF9}, 33, 0, 1'b0);

        repeat (2) @(posedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
